// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with lock for a single-port data memory.
// Byte/word address translation, range check, registered completion.
module dmem_arbiter #(
    parameter int DEPTH     = 64,
    parameter int BYTE_ADDR = 1,
    parameter int LOCK_MAX  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_lock,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_lock,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] CMAX = CW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state, nstate;
    logic [CW-1:0] cnt;
    logic          rr;
    logic          g0, g1;
    logic          forced;
    logic [31:0]   idx0, idx1;
    logic          in0, in1;

    assign idx0 = (BYTE_ADDR != 0) ? {2'b00, p0_addr[31:2]} : p0_addr;
    assign idx1 = (BYTE_ADDR != 0) ? {2'b00, p1_addr[31:2]} : p1_addr;
    assign in0  = idx0 < 32'(DEPTH);
    assign in1  = idx1 < 32'(DEPTH);

    assign forced = (state != IDLE) && (cnt == CMAX);

    // rr = 0 favours p0 when both request from IDLE
    always_comb begin
        g0     = 1'b0;
        g1     = 1'b0;
        nstate = state;
        unique case (state)
            IDLE: begin
                if (p0_req && (!p1_req || !rr)) g0 = 1'b1;
                else if (p1_req)                g1 = 1'b1;
                if (g0 && p0_lock) nstate = OWN0;
                if (g1 && p1_lock) nstate = OWN1;
            end
            OWN0: begin
                g0 = p0_req;
                if (!p0_req || !p0_lock || forced) nstate = IDLE;
            end
            OWN1: begin
                g1 = p1_req;
                if (!p1_req || !p1_lock || forced) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
        if (!rst_n) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
    end

    assign p0_gnt = g0;
    assign p1_gnt = g1;

    always_comb begin
        mem_we = 1'b0;
        mem_a  = 32'd0;
        mem_wd = 32'd0;
        if (g0) begin
            mem_we = p0_we && in0;
            mem_a  = idx0;
            mem_wd = p0_wdata;
        end else if (g1) begin
            mem_we = p1_we && in1;
            mem_a  = idx1;
            mem_wd = p1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rr    <= 1'b0;
        end else begin
            state <= nstate;
            if (state == IDLE)  cnt <= '0;
            else if (cnt != CMAX) cnt <= cnt + 1'b1;
            if (g0)          rr <= 1'b1;
            else if (g1)     rr <= 1'b0;
            else if (forced) rr <= (state == OWN0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= 32'd0;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= 32'd0;
        end else begin
            p0_rvalid <= g0;
            p1_rvalid <= g1;
            p0_err    <= g0 && (!in0 || (forced && p0_lock));
            p1_err    <= g1 && (!in1 || (forced && p1_lock));
            if (g0 && !p0_we) p0_rdata <= in0 ? mem_rd : 32'd0;
            if (g1 && !p1_we) p1_rdata <= in1 ? mem_rd : 32'd0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

    localparam int LM = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(64), .BYTE_ADDR(1), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_lock(p0_lock), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_lock(p1_lock), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    assign mem_rd = (mem_a < 32'd64) ? mem[mem_a[5:0]] : 32'd0;

    always @(posedge clk)
        if (mem_we) mem[mem_a[5:0]] <= mem_wd;

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, mwe;
        logic [31:0] ma, mwd;
        logic        e0, e1;
        logic [31:0] rd;
    } vec_t;

    vec_t vt [10];

    function automatic vec_t mk(
        logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
        logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
        logic g0, logic g1, logic mwe, logic [31:0] ma, logic [31:0] mwd,
        logic e0, logic e1, logic [31:0] rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.ma = ma; v.mwd = mwd;
        v.e0 = e0; v.e1 = e1; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set0(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic l);
        p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d; p0_lock = l;
    endtask

    task automatic set1(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic l);
        p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d; p1_lock = l;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        rst_n = 1'b0;
        set0(1'b1, 1'b1, 32'h8, 32'h1111_1111, 1'b0);
        set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        cyc();
        chk("rst_gnt0", {31'd0, p0_gnt}, 32'd0);
        chk("rst_mwe", {31'd0, mem_we}, 32'd0);
        chk("rst_rv", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
        chk("rst_err", {30'd0, p0_err, p1_err}, 32'd0);
        chk("rst_rd0", p0_rdata, 32'd0);
        chk("rst_rd1", p1_rdata, 32'd0);
        chk("rst_ma", mem_a, 32'd0);
        set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        cyc();

        vt[0] = mk(1,1,32'h8,32'hDEADBEEF, 0,0,0,0,
                   1,0,1,32'd2,32'hDEADBEEF, 0,0,0);
        vt[1] = mk(1,0,32'h8,0, 0,0,0,0,
                   1,0,0,32'd2,0, 0,0,32'hDEADBEEF);
        vt[2] = mk(0,0,0,0, 1,1,32'h20,32'h12345678,
                   0,1,1,32'd8,32'h12345678, 0,0,0);
        vt[3] = mk(1,0,32'h8,0, 1,0,32'h20,0,
                   1,0,0,32'd2,0, 0,0,32'hDEADBEEF);
        vt[4] = mk(1,0,32'h8,0, 1,0,32'h20,0,
                   0,1,0,32'd8,0, 0,0,32'h12345678);
        vt[5] = mk(0,0,0,0, 1,1,32'h100,32'hBAD,
                   0,1,0,32'd64,32'hBAD, 0,1,0);
        vt[6] = mk(1,0,32'h104,0, 0,0,0,0,
                   1,0,0,32'd65,0, 1,0,0);
        vt[7] = mk(0,0,0,0, 0,0,0,0,
                   0,0,0,0,0, 0,0,0);
        vt[8] = mk(1,1,32'hFC,32'hA5A5A5A5, 0,0,0,0,
                   1,0,1,32'd63,32'hA5A5A5A5, 0,0,0);
        vt[9] = mk(0,0,0,0, 1,0,32'hFC,0,
                   0,1,0,32'd63,0, 0,0,32'hA5A5A5A5);

        for (int i = 0; i < 10; i++) begin
            set0(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0, 1'b0);
            set1(vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1, 1'b0);
            #1;
            chk($sformatf("v%0d_gnt", i), {30'd0, p0_gnt, p1_gnt},
                {30'd0, vt[i].g0, vt[i].g1});
            chk($sformatf("v%0d_mwe", i), {31'd0, mem_we}, {31'd0, vt[i].mwe});
            chk($sformatf("v%0d_ma", i), mem_a, vt[i].ma);
            chk($sformatf("v%0d_mwd", i), mem_wd, vt[i].mwd);
            cyc();
            chk($sformatf("v%0d_rv", i), {30'd0, p0_rvalid, p1_rvalid},
                {30'd0, vt[i].g0, vt[i].g1});
            chk($sformatf("v%0d_err", i), {30'd0, p0_err, p1_err},
                {30'd0, vt[i].e0, vt[i].e1});
            if (vt[i].g0 && !vt[i].w0) chk($sformatf("v%0d_rd0", i), p0_rdata, vt[i].rd);
            if (vt[i].g1 && !vt[i].w1) chk($sformatf("v%0d_rd1", i), p1_rdata, vt[i].rd);
        end
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        chk("mem2", mem[2], 32'hDEADBEEF);
        chk("mem8", mem[8], 32'h12345678);
        chk("mem63", mem[63], 32'hA5A5A5A5);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) if (mem[i] == 32'hBAD) seen = 1'b1;
        chk("oor_untouched", {31'd0, seen}, 32'd0);

        // alternating grants with both requesting
        set0(1, 0, 32'h8, 0, 0);
        set1(1, 0, 32'h20, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr%0d_gnt", i), {30'd0, p0_gnt, p1_gnt},
                (i % 2 == 0) ? 32'd2 : 32'd1);
            cyc();
            chk($sformatf("rr%0d_rv", i), {30'd0, p0_rvalid, p1_rvalid},
                (i % 2 == 0) ? 32'd2 : 32'd1);
        end
        set1(0, 0, 0, 0, 0);

        // p1 locked read-modify-write while p0 waits
        #1;
        chk("l1_pre_g0", {31'd0, p0_gnt}, 32'd1);
        cyc();
        set1(1, 0, 32'h10, 0, 1);
        #1;
        chk("l1_a_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd1);
        cyc();
        chk("l1_a_rd", p1_rdata, 32'd0);
        set1(1, 1, 32'h10, 32'hCAFEF00D, 0);
        #1;
        chk("l1_b_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd1);
        chk("l1_b_mwe", {31'd0, mem_we}, 32'd1);
        cyc();
        set1(0, 0, 0, 0, 0);
        #1;
        chk("l1_c_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd2);
        cyc();
        chk("l1_mem4", mem[4], 32'hCAFEF00D);

        // release by dropping req: other port waits one cycle
        set0(1, 0, 32'h8, 0, 1);
        #1;
        chk("rel_lock_g0", {31'd0, p0_gnt}, 32'd1);
        cyc();
        set0(0, 0, 0, 0, 0);
        set1(1, 0, 32'h20, 0, 0);
        #1;
        chk("rel_cycle_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd0);
        cyc();
        #1;
        chk("rel_next_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd1);
        cyc();
        set1(0, 0, 0, 0, 0);
        cyc();

        // lock timeout
        for (int k = 0; k <= LM + 1; k++) begin
            set0(1, 0, 32'h8, 0, 1);
            set1(k >= 1, 0, 32'h20, 0, 0);
            #1;
            chk($sformatf("to%0d_gnt", k), {30'd0, p0_gnt, p1_gnt},
                (k <= LM) ? 32'd2 : 32'd1);
            cyc();
            if (k <= LM)
                chk($sformatf("to%0d_err0", k), {31'd0, p0_err},
                    (k == LM) ? 32'd1 : 32'd0);
        end
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        cyc();

        // reset mid-write
        set0(1, 1, 32'h40, 32'h5555_5555, 0);
        #1;
        chk("rw_pre_mwe", {31'd0, mem_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_mwe", {31'd0, mem_we}, 32'd0);
        chk("rw_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd0);
        chk("rw_rv", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
        chk("rw_rd0", p0_rdata, 32'd0);
        cyc();
        chk("rw_mem16", mem[16], 32'd0);
        set0(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    always @(negedge clk)
        if (rst_n && p0_rvalid && p1_rvalid) begin
            checks++;
            errors++;
            $display("FAIL dual_rvalid: got 11 expected at most one");
        end

endmodule
